// File: rtl/writeback_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : writeback_arbiter_pkg
// Purpose  : Core datapath sizes and shared types for the writeback arbiter.
// Revision : 1.0
// ============================================================================
package writeback_arbiter_pkg;

    localparam int XLEN             = 32;
    localparam int REG_ADDR_WIDTH   = 5;
    localparam int NUM_REGS         = 1 << REG_ADDR_WIDTH;
    localparam int WB_STARVE_LIMIT  = 4;
    localparam int STARVE_CNT_WIDTH = 4;

    typedef logic [REG_ADDR_WIDTH-1:0] reg_addr_t;
    typedef logic [XLEN-1:0]           xlen_t;

    typedef enum logic [1:0] {
        GRANT_NONE = 2'd0,
        GRANT_ALU  = 2'd1,
        GRANT_LOAD = 2'd2
    } grant_e;

endpackage
`default_nettype wire

// File: rtl/writeback_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : writeback_arbiter_if
// Purpose  : Producer handshakes, issue-stage hazard lookup and RF write port.
// Revision : 1.0
// ============================================================================
interface writeback_arbiter_if;
    import writeback_arbiter_pkg::*;

    logic      i_Alu_Valid;
    logic      o_Alu_Ready;
    reg_addr_t i_Alu_Addr;
    xlen_t     i_Alu_Data;
    logic      i_Load_Valid;
    logic      o_Load_Ready;
    reg_addr_t i_Load_Addr;
    xlen_t     i_Load_Data;
    logic      i_Load_Issue;
    reg_addr_t i_Load_Issue_Addr;
    reg_addr_t i_Hazard_Addr_1;
    reg_addr_t i_Hazard_Addr_2;
    reg_addr_t i_Hazard_Addr_Dest;
    logic      o_Hazard;
    logic      o_Write_Enable;
    reg_addr_t o_Write_Addr;
    xlen_t     o_Write_Data;

    modport master (
        output i_Alu_Valid, i_Alu_Addr, i_Alu_Data,
        output i_Load_Valid, i_Load_Addr, i_Load_Data,
        output i_Load_Issue, i_Load_Issue_Addr,
        output i_Hazard_Addr_1, i_Hazard_Addr_2, i_Hazard_Addr_Dest,
        input  o_Alu_Ready, o_Load_Ready, o_Hazard,
        input  o_Write_Enable, o_Write_Addr, o_Write_Data
    );

    modport slave (
        input  i_Alu_Valid, i_Alu_Addr, i_Alu_Data,
        input  i_Load_Valid, i_Load_Addr, i_Load_Data,
        input  i_Load_Issue, i_Load_Issue_Addr,
        input  i_Hazard_Addr_1, i_Hazard_Addr_2, i_Hazard_Addr_Dest,
        output o_Alu_Ready, o_Load_Ready, o_Hazard,
        output o_Write_Enable, o_Write_Addr, o_Write_Data
    );

endinterface
`default_nettype wire

// File: rtl/writeback_arbiter_load_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : writeback_arbiter_load_scoreboard
// Purpose  : Per-register outstanding-load bits and three-way hazard lookup.
// Revision : 1.0
// ============================================================================
module writeback_arbiter_load_scoreboard
    import writeback_arbiter_pkg::*;
(
    input  wire       i_Clock,
    input  wire       i_Reset_N,
    input  wire       i_Set,
    input  reg_addr_t i_Set_Addr,
    input  wire       i_Clear,
    input  reg_addr_t i_Clear_Addr,
    input  reg_addr_t i_Addr_1,
    input  reg_addr_t i_Addr_2,
    input  reg_addr_t i_Addr_Dest,
    output logic      o_Hazard
);

    logic [NUM_REGS-1:0] r_busy;

    // Set is applied after clear so a reissued load keeps its register busy.
    always_ff @(posedge i_Clock) begin
        if (!i_Reset_N) begin
            r_busy <= '0;
        end else begin
            if (i_Clear) begin
                r_busy[i_Clear_Addr] <= 1'b0;
            end
            if (i_Set && (i_Set_Addr != '0)) begin
                r_busy[i_Set_Addr] <= 1'b1;
            end
            r_busy[0] <= 1'b0;
        end
    end

    assign o_Hazard = r_busy[i_Addr_1] | r_busy[i_Addr_2] | r_busy[i_Addr_Dest];

endmodule
`default_nettype wire

// File: rtl/writeback_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : writeback_arbiter
// Purpose  : Shares the RF write port between ALU and load writebacks, with
//            load priority, ALU anti-starvation and a load scoreboard.
// Revision : 1.0
// ============================================================================
module writeback_arbiter
    import writeback_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = WB_STARVE_LIMIT
) (
    input  wire                i_Clock,
    input  wire                i_Reset_N,
    writeback_arbiter_if.slave wb
);

    localparam logic [STARVE_CNT_WIDTH-1:0] c_STARVE_LIMIT = STARVE_CNT_WIDTH'(STARVE_LIMIT);

    logic [STARVE_CNT_WIDTH-1:0] r_starve_cnt;
    logic                        r_write_enable;
    reg_addr_t                   r_write_addr;
    xlen_t                       r_write_data;
    logic                        w_starved;
    logic                        w_alu_ready;
    logic                        w_load_ready;
    grant_e                      w_grant;
    reg_addr_t                   w_grant_addr;
    xlen_t                       w_grant_data;

    // Readiness depends only on the other side's valid, never on its own.
    assign w_starved    = (r_starve_cnt == c_STARVE_LIMIT);
    assign w_load_ready = !(wb.i_Alu_Valid && w_starved);
    assign w_alu_ready  = !wb.i_Load_Valid || w_starved;

    always_comb begin
        w_grant      = GRANT_NONE;
        w_grant_addr = wb.i_Load_Addr;
        w_grant_data = wb.i_Load_Data;
        if (wb.i_Load_Valid && w_load_ready) begin
            w_grant = GRANT_LOAD;
        end else if (wb.i_Alu_Valid && w_alu_ready) begin
            w_grant      = GRANT_ALU;
            w_grant_addr = wb.i_Alu_Addr;
            w_grant_data = wb.i_Alu_Data;
        end
    end

    always_ff @(posedge i_Clock) begin
        if (!i_Reset_N) begin
            r_starve_cnt <= '0;
        end else if (wb.i_Alu_Valid && !w_alu_ready) begin
            if (!w_starved) begin
                r_starve_cnt <= r_starve_cnt + 1'b1;
            end
        end else begin
            r_starve_cnt <= '0;
        end
    end

    // Writes to x0 are accepted but never reach the register file.
    always_ff @(posedge i_Clock) begin
        if (!i_Reset_N) begin
            r_write_enable <= 1'b0;
            r_write_addr   <= '0;
            r_write_data   <= '0;
        end else if ((w_grant != GRANT_NONE) && (w_grant_addr != '0)) begin
            r_write_enable <= 1'b1;
            r_write_addr   <= w_grant_addr;
            r_write_data   <= w_grant_data;
        end else begin
            r_write_enable <= 1'b0;
        end
    end

    writeback_arbiter_load_scoreboard u_load_scoreboard (
        .i_Clock      (i_Clock),
        .i_Reset_N    (i_Reset_N),
        .i_Set        (wb.i_Load_Issue),
        .i_Set_Addr   (wb.i_Load_Issue_Addr),
        .i_Clear      (w_grant == GRANT_LOAD),
        .i_Clear_Addr (wb.i_Load_Addr),
        .i_Addr_1     (wb.i_Hazard_Addr_1),
        .i_Addr_2     (wb.i_Hazard_Addr_2),
        .i_Addr_Dest  (wb.i_Hazard_Addr_Dest),
        .o_Hazard     (wb.o_Hazard)
    );

    assign wb.o_Alu_Ready    = w_alu_ready;
    assign wb.o_Load_Ready   = w_load_ready;
    assign wb.o_Write_Enable = r_write_enable;
    assign wb.o_Write_Addr   = r_write_addr;
    assign wb.o_Write_Data   = r_write_data;

endmodule
`default_nettype wire

// File: tb/tb_writeback_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_writeback_arbiter
// Purpose  : Directed self-checking bench for writeback_arbiter.
// Revision : 1.0
// ============================================================================
module tb_writeback_arbiter;
    import writeback_arbiter_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    writeback_arbiter_if wb ();

    writeback_arbiter #(.STARVE_LIMIT(4)) dut (
        .i_Clock   (clk),
        .i_Reset_N (rst_n),
        .wb        (wb)
    );

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_inputs();
        wb.i_Alu_Valid        = 1'b0;
        wb.i_Alu_Addr         = '0;
        wb.i_Alu_Data         = '0;
        wb.i_Load_Valid       = 1'b0;
        wb.i_Load_Addr        = '0;
        wb.i_Load_Data        = '0;
        wb.i_Load_Issue       = 1'b0;
        wb.i_Load_Issue_Addr  = '0;
        wb.i_Hazard_Addr_1    = '0;
        wb.i_Hazard_Addr_2    = '0;
        wb.i_Hazard_Addr_Dest = '0;
    endtask

    task automatic test_reset();
        int bad;
        rst_n                = 1'b0;
        wb.i_Alu_Valid       = 1'b1;
        wb.i_Alu_Addr        = 5'd5;
        wb.i_Alu_Data        = 32'h1111_1111;
        wb.i_Load_Valid      = 1'b1;
        wb.i_Load_Addr       = 5'd6;
        wb.i_Load_Data       = 32'h2222_2222;
        wb.i_Load_Issue      = 1'b1;
        wb.i_Load_Issue_Addr = 5'd5;
        tick();
        tick();
        n_tests++;
        if (wb.o_Write_Enable !== 1'b0 || wb.o_Write_Addr !== 5'd0 || wb.o_Write_Data !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_write: we=%0b addr=%0d data=%h, want 0/0/0",
                     wb.o_Write_Enable, wb.o_Write_Addr, wb.o_Write_Data);
        end
        bad = 0;
        for (int r = 0; r < NUM_REGS; r++) begin
            wb.i_Hazard_Addr_1    = 5'(r);
            wb.i_Hazard_Addr_2    = 5'(r);
            wb.i_Hazard_Addr_Dest = 5'(r);
            #1;
            if (wb.o_Hazard !== 1'b0) bad++;
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL reset_busy: %0d registers report hazard, want 0", bad);
        end
        idle_inputs();
        rst_n = 1'b1;
        #1;
        n_tests++;
        if (wb.o_Alu_Ready !== 1'b1 || wb.o_Load_Ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready: alu_ready=%0b load_ready=%0b, want 1/1",
                     wb.o_Alu_Ready, wb.o_Load_Ready);
        end
        tick();
    endtask

    task automatic test_alu_write();
        wb.i_Alu_Valid = 1'b1;
        wb.i_Alu_Addr  = 5'd5;
        wb.i_Alu_Data  = 32'hDEAD_BEEF;
        tick();
        wb.i_Alu_Valid = 1'b0;
        n_tests++;
        if (wb.o_Write_Enable !== 1'b1 || wb.o_Write_Addr !== 5'd5 || wb.o_Write_Data !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL alu_write: we=%0b addr=%0d data=%h, want 1/5/deadbeef",
                     wb.o_Write_Enable, wb.o_Write_Addr, wb.o_Write_Data);
        end
        wb.i_Alu_Valid = 1'b1;
        wb.i_Alu_Addr  = 5'd0;
        wb.i_Alu_Data  = 32'h0000_1234;
        #1;
        n_tests++;
        if (wb.o_Alu_Ready !== 1'b1) begin
            n_fail++;
            $display("FAIL alu_x0_ready: got %0b, want 1", wb.o_Alu_Ready);
        end
        tick();
        wb.i_Alu_Valid = 1'b0;
        n_tests++;
        if (wb.o_Write_Enable !== 1'b0 || wb.o_Write_Addr !== 5'd5 || wb.o_Write_Data !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL alu_x0_write: we=%0b addr=%0d data=%h, want 0/5/deadbeef",
                     wb.o_Write_Enable, wb.o_Write_Addr, wb.o_Write_Data);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [4:0] addrs [3];
        addrs = '{5'd10, 5'd11, 5'd12};
        for (int i = 0; i < 3; i++) begin
            wb.i_Alu_Valid = 1'b1;
            wb.i_Alu_Addr  = addrs[i];
            wb.i_Alu_Data  = 32'hB000_0000 + 32'(i);
            tick();
            n_tests++;
            if (wb.o_Write_Enable !== 1'b1 || wb.o_Write_Addr !== addrs[i] ||
                wb.o_Write_Data !== 32'hB000_0000 + 32'(i)) begin
                n_fail++;
                $display("FAIL back_to_back[%0d]: we=%0b addr=%0d data=%h, want 1/%0d/%h",
                         i, wb.o_Write_Enable, wb.o_Write_Addr, wb.o_Write_Data,
                         addrs[i], 32'hB000_0000 + 32'(i));
            end
        end
        wb.i_Alu_Valid = 1'b0;
        tick();
    endtask

    task automatic test_priority_starvation();
        logic [4:0] exp_addr [10];
        exp_addr = '{5'd3, 5'd3, 5'd3, 5'd3, 5'd2, 5'd3, 5'd3, 5'd3, 5'd3, 5'd2};
        wb.i_Alu_Valid  = 1'b1;
        wb.i_Alu_Addr   = 5'd2;
        wb.i_Alu_Data   = 32'h0000_00A0;
        wb.i_Load_Valid = 1'b1;
        wb.i_Load_Addr  = 5'd3;
        wb.i_Load_Data  = 32'h0000_00B0;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_tests++;
            if (wb.o_Write_Enable !== 1'b1 || wb.o_Write_Addr !== exp_addr[i]) begin
                n_fail++;
                $display("FAIL starve_grant[%0d]: we=%0b addr=%0d, want 1/%0d",
                         i, wb.o_Write_Enable, wb.o_Write_Addr, exp_addr[i]);
            end
        end
        wb.i_Alu_Valid  = 1'b0;
        wb.i_Load_Valid = 1'b0;
        tick();
    endtask

    task automatic test_scoreboard();
        wb.i_Load_Issue      = 1'b1;
        wb.i_Load_Issue_Addr = 5'd7;
        tick();
        wb.i_Load_Issue    = 1'b0;
        wb.i_Hazard_Addr_1 = 5'd7;
        #1;
        n_tests++;
        if (wb.o_Hazard !== 1'b1) begin
            n_fail++;
            $display("FAIL sb_set_rs1: hazard=%0b, want 1", wb.o_Hazard);
        end
        wb.i_Hazard_Addr_1    = 5'd0;
        wb.i_Hazard_Addr_Dest = 5'd7;
        #1;
        n_tests++;
        if (wb.o_Hazard !== 1'b1) begin
            n_fail++;
            $display("FAIL sb_set_rd: hazard=%0b, want 1", wb.o_Hazard);
        end
        wb.i_Load_Valid = 1'b1;
        wb.i_Load_Addr  = 5'd7;
        wb.i_Load_Data  = 32'h0000_0077;
        #1;
        n_tests++;
        if (wb.o_Hazard !== 1'b1) begin
            n_fail++;
            $display("FAIL sb_same_cycle_clear: hazard=%0b, want 1", wb.o_Hazard);
        end
        tick();
        wb.i_Load_Valid = 1'b0;
        #1;
        n_tests++;
        if (wb.o_Hazard !== 1'b0 || wb.o_Write_Enable !== 1'b1 ||
            wb.o_Write_Addr !== 5'd7 || wb.o_Write_Data !== 32'h0000_0077) begin
            n_fail++;
            $display("FAIL sb_clear: hazard=%0b we=%0b addr=%0d data=%h, want 0/1/7/00000077",
                     wb.o_Hazard, wb.o_Write_Enable, wb.o_Write_Addr, wb.o_Write_Data);
        end
        wb.i_Hazard_Addr_Dest = 5'd0;
        wb.i_Load_Issue       = 1'b1;
        wb.i_Load_Issue_Addr  = 5'd0;
        tick();
        wb.i_Load_Issue = 1'b0;
        #1;
        n_tests++;
        if (wb.o_Hazard !== 1'b0) begin
            n_fail++;
            $display("FAIL sb_issue_x0: hazard=%0b, want 0", wb.o_Hazard);
        end
    endtask

    task automatic test_collision();
        wb.i_Load_Issue      = 1'b1;
        wb.i_Load_Issue_Addr = 5'd9;
        tick();
        wb.i_Load_Valid = 1'b1;
        wb.i_Load_Addr  = 5'd9;
        wb.i_Load_Data  = 32'h0000_0099;
        tick();
        wb.i_Load_Valid    = 1'b0;
        wb.i_Load_Issue    = 1'b0;
        wb.i_Hazard_Addr_2 = 5'd9;
        #1;
        n_tests++;
        if (wb.o_Hazard !== 1'b1) begin
            n_fail++;
            $display("FAIL collision_set_wins: hazard=%0b, want 1", wb.o_Hazard);
        end
        wb.i_Load_Valid = 1'b1;
        tick();
        wb.i_Load_Valid = 1'b0;
        #1;
        n_tests++;
        if (wb.o_Hazard !== 1'b0) begin
            n_fail++;
            $display("FAIL collision_final_clear: hazard=%0b, want 0", wb.o_Hazard);
        end
        wb.i_Hazard_Addr_2 = 5'd0;
    endtask

    task automatic test_reset_mid();
        wb.i_Load_Issue      = 1'b1;
        wb.i_Load_Issue_Addr = 5'd3;
        tick();
        wb.i_Load_Issue    = 1'b0;
        wb.i_Hazard_Addr_1 = 5'd3;
        wb.i_Alu_Valid     = 1'b1;
        wb.i_Alu_Addr      = 5'd4;
        wb.i_Alu_Data      = 32'h0000_0044;
        #1;
        n_tests++;
        if (wb.o_Hazard !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_busy_before: hazard=%0b, want 1", wb.o_Hazard);
        end
        rst_n = 1'b0;
        tick();
        wb.i_Alu_Valid = 1'b0;
        rst_n          = 1'b1;
        #1;
        n_tests++;
        if (wb.o_Write_Enable !== 1'b0 || wb.o_Write_Addr !== 5'd0 ||
            wb.o_Write_Data !== 32'd0 || wb.o_Hazard !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset: we=%0b addr=%0d data=%h hazard=%0b, want 0/0/0/0",
                     wb.o_Write_Enable, wb.o_Write_Addr, wb.o_Write_Data, wb.o_Hazard);
        end
        wb.i_Hazard_Addr_1 = 5'd0;
        tick();
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        test_reset();
        test_alu_write();
        test_back_to_back();
        test_priority_starvation();
        test_scoreboard();
        test_collision();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
